// File: rtl/bus_timer_irq_pkg.sv
// Shared constants for the bus-mapped interval timer: register offsets, bit positions
// and reset values.
package bus_timer_irq_pkg;

    typedef enum logic [1:0] {
        REG_LO   = 2'd0,
        REG_HI   = 2'd1,
        REG_CTRL = 2'd2,
        REG_STAT = 2'd3
    } reg_off_e;

    localparam int unsigned CTRL_RUN  = 0;
    localparam int unsigned CTRL_CONT = 1;
    localparam int unsigned CTRL_IE   = 2;
    localparam int unsigned CTRL_NSEL = 3;

    localparam int unsigned STAT_FLAG = 0;
    localparam int unsigned STAT_PEND = 7;

    localparam logic [15:0] RELOAD_RST = 16'h0000;
    localparam logic [15:0] COUNT_RST  = 16'h0000;
    localparam logic [7:0]  SNAP_RST   = 8'h00;
    localparam logic [7:0]  DATA_RST   = 8'h00;

    // True when addr falls in the 4-byte block at base (base[1:0] assumed 0).
    function automatic logic in_block(logic [15:0] addr, logic [15:0] base);
        return (addr | 16'h0003) == (base | 16'h0003);
    endfunction

endpackage

// File: rtl/bus_timer_prescaler.sv
// Divides clk into timer ticks: one tick every PRESCALE cycles while run is high.
module bus_timer_prescaler #(
    parameter int unsigned PRESCALE = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    input  logic clear,
    output logic tick
);

    localparam int unsigned W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [W-1:0] LAST = W'(PRESCALE - 1);

    logic [W-1:0] cnt_q;

    assign tick = run && (cnt_q == LAST);

    always_ff @(posedge clk) begin
        if (reset || clear || !run || tick) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/bus_timer_irq.sv
// 16-bit interval timer / interrupt source on the early-decode CPU bus.
// Define BUS_TIMER_NMI_EN to implement CTRL.nsel and route the interrupt to nmi.
module bus_timer_irq
    import bus_timer_irq_pkg::*;
#(
    parameter logic [15:0] BASE     = 16'hbff0,
    parameter int unsigned PRESCALE = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ready,
    input  logic [15:0] address,
    input  logic [15:0] address_next,
    input  logic        write_next,
    input  logic [7:0]  data_i_bus,
    output logic [7:0]  data_o,
    output logic        cs,
    output logic        irq,
    output logic        nmi
);

    logic [15:0] reload_q, count_q;
    logic [7:0]  snap_q, data_q, rd_data;
    logic        run_q, cont_q, ie_q, flag_q, nsel;
    logic        hit_next, wr_en, rd_en;
    logic        wr_lo, wr_hi, wr_ctrl, wr_stat;
    logic        tick, expire;
    reg_off_e    off;

    assign cs       = in_block(address, BASE);
    assign hit_next = in_block(address_next, BASE);
    assign off      = reg_off_e'(address_next[1:0]);
    assign wr_en    = hit_next && write_next && ready;
    assign rd_en    = hit_next && !write_next && ready;
    assign wr_lo    = wr_en && (off == REG_LO);
    assign wr_hi    = wr_en && (off == REG_HI);
    assign wr_ctrl  = wr_en && (off == REG_CTRL);
    assign wr_stat  = wr_en && (off == REG_STAT);

    bus_timer_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk   (clk),
        .reset (reset),
        .run   (run_q),
        .clear (wr_hi),
        .tick  (tick)
    );

    // A HI write reloads the counter and swallows any tick on the same edge.
    assign expire = tick && !wr_hi && (count_q == 16'h0000);

    always_ff @(posedge clk) begin
        if (reset) begin
            reload_q <= RELOAD_RST;
            count_q  <= COUNT_RST;
            snap_q   <= SNAP_RST;
            data_q   <= DATA_RST;
            run_q    <= 1'b0;
            cont_q   <= 1'b0;
            ie_q     <= 1'b0;
            flag_q   <= 1'b0;
        end else begin
            if (wr_lo) reload_q[7:0] <= data_i_bus;
            if (wr_hi) reload_q[15:8] <= data_i_bus;

            if (wr_hi) begin
                count_q <= {data_i_bus, reload_q[7:0]};
            end else if (tick) begin
                if (count_q != 16'h0000) begin
                    count_q <= count_q - 16'h0001;
                end else if (cont_q) begin
                    count_q <= reload_q;
                end
            end

            if (wr_ctrl) begin
                run_q  <= data_i_bus[CTRL_RUN];
                cont_q <= data_i_bus[CTRL_CONT];
                ie_q   <= data_i_bus[CTRL_IE];
            end else if (expire && !cont_q) begin
                run_q <= 1'b0;
            end

            // Hardware set beats a same-edge software clear.
            if (expire) begin
                flag_q <= 1'b1;
            end else if (wr_stat && data_i_bus[STAT_FLAG]) begin
                flag_q <= 1'b0;
            end

            if (rd_en) begin
                data_q <= rd_data;
                if (off == REG_LO) snap_q <= count_q[15:8];
            end
        end
    end

`ifdef BUS_TIMER_NMI_EN
    logic nsel_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            nsel_q <= 1'b0;
        end else if (wr_ctrl) begin
            nsel_q <= data_i_bus[CTRL_NSEL];
        end
    end

    assign nsel = nsel_q;
`else
    assign nsel = 1'b0;
`endif

    always_comb begin
        rd_data = DATA_RST;
        unique case (off)
            REG_LO:   rd_data = count_q[7:0];
            REG_HI:   rd_data = snap_q;
            REG_CTRL: begin
                rd_data[CTRL_RUN]  = run_q;
                rd_data[CTRL_CONT] = cont_q;
                rd_data[CTRL_IE]   = ie_q;
                rd_data[CTRL_NSEL] = nsel;
            end
            REG_STAT: begin
                rd_data[STAT_FLAG] = flag_q;
                rd_data[STAT_PEND] = irq | nmi;
            end
            default: rd_data = DATA_RST;
        endcase
    end

    assign data_o = data_q;
    assign irq    = flag_q && ie_q && !nsel;
    assign nmi    = flag_q && ie_q && nsel;

endmodule

// File: tb/tb_bus_timer_irq.sv
// Bench for bus_timer_irq: directed scenarios plus random bus traffic, checked against a
// cycle-level behavioural model for PRESCALE=1 and PRESCALE=3 instances.
module tb_bus_timer_irq;

    localparam logic [15:0] BASE = 16'hbff0;
`ifdef BUS_TIMER_NMI_EN
    localparam bit NMI_EN = 1'b1;
`else
    localparam bit NMI_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset, ready, write_next;
    logic [15:0] address, address_next;
    logic [7:0]  data_i_bus;
    logic [7:0]  data_o1, data_o3;
    logic        cs1, cs3, irq1, irq3, nmi1, nmi3;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    bit auto_en  = 1'b0;

    always #5 clk = ~clk;

    bus_timer_irq #(.BASE(BASE), .PRESCALE(1)) dut (
        .clk(clk), .reset(reset), .ready(ready), .address(address),
        .address_next(address_next), .write_next(write_next), .data_i_bus(data_i_bus),
        .data_o(data_o1), .cs(cs1), .irq(irq1), .nmi(nmi1)
    );

    bus_timer_irq #(.BASE(BASE), .PRESCALE(3)) dut3 (
        .clk(clk), .reset(reset), .ready(ready), .address(address),
        .address_next(address_next), .write_next(write_next), .data_i_bus(data_i_bus),
        .data_o(data_o3), .cs(cs3), .irq(irq3), .nmi(nmi3)
    );

    typedef struct packed {
        logic [15:0] reload;
        logic [15:0] count;
        logic [7:0]  snap;
        logic [7:0]  dout;
        logic        run, cont, ie, nsel, flag;
        logic [8:0]  pre;
    } mdl_t;

    mdl_t m1 = '0;
    mdl_t m3 = '0;

    function automatic logic m_irq(mdl_t s);
        return s.flag & s.ie & ~s.nsel;
    endfunction

    function automatic logic m_nmi(mdl_t s);
        return s.flag & s.ie & s.nsel;
    endfunction

    // One clock edge of the timer as described by its register-level rules.
    function automatic mdl_t step(mdl_t s, int unsigned p, logic rst, logic [15:0] an,
                                  logic we, logic [7:0] d, logic rdy);
        mdl_t n = s;
        logic tck, setf, hit;
        int   off;
        if (rst) return '0;
        hit  = (an >= BASE) && (an <= BASE + 16'd3);
        off  = int'(an - BASE);
        tck  = s.run && (32'(s.pre) == p - 1);
        n.pre = (!s.run || tck) ? 9'd0 : s.pre + 9'd1;
        setf = 1'b0;
        if (tck) begin
            if (s.count == 0) begin
                setf = 1'b1;
                n.flag = 1'b1;
                if (s.cont) n.count = s.reload;
                else n.run = 1'b0;
            end else begin
                n.count = s.count - 16'd1;
            end
        end
        if (hit && rdy && we) begin
            case (off)
                0: n.reload[7:0] = d;
                1: begin
                    n.reload[15:8] = d;
                    n.count = {d, s.reload[7:0]};
                    n.pre = 9'd0;
                    n.flag = s.flag;
                    n.run = s.run;
                end
                2: begin
                    n.run = d[0];
                    n.cont = d[1];
                    n.ie = d[2];
                    n.nsel = NMI_EN ? d[3] : 1'b0;
                end
                default: if (d[0] && !setf) n.flag = 1'b0;
            endcase
        end
        if (hit && rdy && !we) begin
            case (off)
                0: begin
                    n.dout = s.count[7:0];
                    n.snap = s.count[15:8];
                end
                1: n.dout = s.snap;
                2: n.dout = {4'b0000, s.nsel, s.ie, s.cont, s.run};
                default: n.dout = {m_irq(s) | m_nmi(s), 6'b000000, s.flag};
            endcase
        end
        return n;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        cyc++;
        m1 = step(m1, 1, reset, address_next, write_next, data_i_bus, ready);
        m3 = step(m3, 3, reset, address_next, write_next, data_i_bus, ready);
        address <= address_next;
    end

    always @(negedge clk) begin
        if (auto_en) begin
            check_eq("m1_data", 32'(data_o1), 32'(m1.dout));
            check_eq("m1_irq", 32'(irq1), 32'(m_irq(m1)));
            check_eq("m1_nmi", 32'(nmi1), 32'(m_nmi(m1)));
            check_eq("m1_cs", 32'(cs1), 32'((address >= BASE) && (address <= BASE + 16'd3)));
            check_eq("m3_data", 32'(data_o3), 32'(m3.dout));
            check_eq("m3_irq", 32'(irq3), 32'(m_irq(m3)));
            check_eq("m3_nmi", 32'(nmi3), 32'(m_nmi(m3)));
            check_eq("m3_cs", 32'(cs3), 32'(cs1));
        end
    end

    // Present one bus transaction for one edge; called at a negedge, returns at the next.
    task automatic bus_op(input logic [1:0] off, input logic we, input logic [7:0] d,
                          input logic rdy);
        address_next = BASE + 16'(off);
        write_next   = we;
        data_i_bus   = d;
        ready        = rdy;
        @(negedge clk);
        address_next = 16'h0000;
        write_next   = 1'b0;
        data_i_bus   = 8'h00;
        ready        = 1'b1;
    endtask

    task automatic wr(input logic [1:0] off, input logic [7:0] d);
        bus_op(off, 1'b1, d, 1'b1);
    endtask

    task automatic rd(input logic [1:0] off, output logic [7:0] v);
        bus_op(off, 1'b0, 8'h00, 1'b1);
        v = data_o1;
    endtask

    task automatic wait_int(input int limit);
        int n = 0;
        while (!(irq1 || nmi1) && n < limit) begin
            @(negedge clk);
            n++;
        end
    endtask

    initial begin
        logic [7:0] v;
        int c0, t0;
        bit seen;
        reset = 1'b1; ready = 1'b1; write_next = 1'b0;
        address_next = 16'h0000; data_i_bus = 8'h00; address = 16'h0000;

        repeat (4) @(negedge clk);
        check_eq("rst_data", 32'(data_o1), 32'h0);
        check_eq("rst_irq", 32'(irq1), 32'h0);
        check_eq("rst_nmi", 32'(nmi1), 32'h0);
        reset = 1'b0;
        auto_en = 1'b1;
        for (int r = 0; r < 4; r++) begin
            rd(2'(r), v);
            check_eq("rst_reg", 32'(v), 32'h0);
        end

        // One-shot: reload 4 -> 5 ticks to expiry.
        wr(2'd0, 8'h04); wr(2'd1, 8'h00); wr(2'd2, 8'h05);
        c0 = cyc;
        wait_int(20);
        check_eq("oneshot_lat", 32'(cyc - c0), 32'd5);
        rd(2'd2, v); check_eq("oneshot_ctrl", 32'(v), 32'h04);
        rd(2'd0, v); check_eq("oneshot_cnt", 32'(v), 32'h00);
        rd(2'd3, v); check_eq("oneshot_stat", 32'(v), 32'h81);
        wr(2'd3, 8'h01);
        rd(2'd3, v); check_eq("stat_w1c", 32'(v), 32'h00);
        wr(2'd2, 8'h00);

        // Continuous with reload 2: period of 3.
        wr(2'd0, 8'h02); wr(2'd1, 8'h00); wr(2'd2, 8'h07);
        wait_int(20);
        t0 = cyc;
        for (int k = 0; k < 3; k++) begin
            wr(2'd3, 8'h01);
            check_eq("cont_clr", 32'(irq1), 32'h0);
            wait_int(20);
            check_eq("cont_period", 32'(cyc - t0), 32'd3);
            t0 = cyc;
        end
        wr(2'd3, 8'h01);
        @(negedge clk);
        wr(2'd3, 8'h01);                // lands on the setting tick
        check_eq("w1c_vs_set", 32'(irq1), 32'h1);
        wr(2'd2, 8'h00); wr(2'd3, 8'h01);

        // Snapshot: HI returns the high byte captured by the LO read.
        wr(2'd0, 8'h00); wr(2'd1, 8'h01); wr(2'd2, 8'h01);
        rd(2'd0, v); check_eq("snap_lo", 32'(v), 32'h00);
        @(negedge clk);
        rd(2'd1, v); check_eq("snap_hi", 32'(v), 32'h01);
        wr(2'd2, 8'h00);

        // ready gating.
        wr(2'd3, 8'h01); wr(2'd0, 8'h01); wr(2'd1, 8'h00);
        bus_op(2'd2, 1'b1, 8'h05, 1'b0);
        rd(2'd2, v); check_eq("rdy0_ctrl", 32'(v), 32'h00);
        seen = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            seen |= irq1;
        end
        check_eq("rdy0_noirq", 32'(seen), 32'h0);
        wr(2'd2, 8'h05);
        rd(2'd2, v); check_eq("rdy1_ctrl", 32'(v), 32'h05);
        wait_int(20);
        check_eq("rdy1_irq", 32'(irq1), 32'h1);
        rd(2'd2, v);
        bus_op(2'd3, 1'b0, 8'h00, 1'b0);
        check_eq("rdy0_hold", 32'(data_o1), 32'h04);
        wr(2'd3, 8'h01); wr(2'd2, 8'h00);

        // Interrupt routing select.
        wr(2'd0, 8'h01); wr(2'd1, 8'h00); wr(2'd2, 8'h0d);
        c0 = cyc;
        rd(2'd2, v); check_eq("nsel_ctrl", 32'(v), NMI_EN ? 32'h0d : 32'h05);
        wait_int(20);
        check_eq("nsel_lat", 32'(cyc - c0), 32'd2);
        check_eq("nsel_nmi", 32'(nmi1), 32'(NMI_EN));
        check_eq("nsel_irq", 32'(irq1), 32'(!NMI_EN));
        wr(2'd3, 8'h01); wr(2'd2, 8'h00);

        // Random traffic, including occasional mid-count resets.
        for (int i = 0; i < 2000; i++) begin
            int r;
            r = int'($urandom_range(0, 99));
            reset = (r < 1);
            if (r < 30) address_next = 16'($urandom);
            else address_next = BASE + 16'($urandom_range(0, 3));
            write_next = 1'($urandom_range(0, 1));
            ready = ($urandom_range(0, 9) != 0);
            if (address_next == BASE + 16'd1)
                data_i_bus = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'($urandom_range(0, 1));
            else if (address_next == BASE)
                data_i_bus = 8'($urandom_range(0, 7));
            else
                data_i_bus = 8'($urandom);
            @(negedge clk);
        end
        reset = 1'b0; ready = 1'b1; write_next = 1'b0; address_next = 16'h0000;
        repeat (3) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
